// File: rtl/ekg_pkg.sv
// Shared types and default widths for the EKG beat-window control path.
package ekg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int TICK_WIDTH_DEF  = 16;
  localparam int COUNT_WIDTH_DEF = 8;

endpackage

// File: rtl/window_timer.sv
// Window tick counter: latches the window length on load, counts ticks and
// raises done_out combinationally on the tick that completes the window.
module window_timer
  import ekg_pkg::*;
#(
  parameter int TICK_WIDTH = TICK_WIDTH_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_in,
  input  logic                  clear_in,
  input  logic [TICK_WIDTH-1:0] window_in,
  input  logic                  tick_in,
  output logic                  done_out
);

  localparam logic [TICK_WIDTH-1:0] ONE = TICK_WIDTH'(1);

  logic [TICK_WIDTH-1:0] win_q, win_d;
  logic [TICK_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done;

  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    done  = tick_in && (cnt_q == (win_q - ONE));
    if (load_in) begin
      // A zero-length window would never terminate; treat it as one tick.
      win_d = (window_in == '0) ? ONE : window_in;
      cnt_d = '0;
    end else if (clear_in) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = done ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_out = done;

endmodule

// File: rtl/beat_window_ctrl.sv
// Counts rising edges of the beat detector over tick-timed windows and
// publishes each window's count through a valid/ready result register.
module beat_window_ctrl
  import ekg_pkg::*;
#(
  parameter int TICK_WIDTH  = TICK_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   stop_in,
  input  logic                   continuous_in,
  input  logic [TICK_WIDTH-1:0]  window_ticks_in,
  input  logic                   tick_in,
  input  logic                   beat_in,
  output logic [COUNT_WIDTH-1:0] result_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   sat_out,
  output logic                   busy_out,
  output logic                   dropped_out
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   beat_q;
  logic [COUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                   sat_q, sat_d;
  logic                   cont_q, cont_d;
  logic [COUNT_WIDTH-1:0] result_q, result_d;
  logic                   res_sat_q, res_sat_d;
  logic                   valid_q, valid_d;
  logic                   dropped_q, dropped_d;

  logic                   beat_pulse;
  logic                   is_run;
  logic                   load;
  logic                   clear;
  logic                   win_done;
  logic                   win_end;
  logic                   handshake;
  logic                   at_max;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [COUNT_WIDTH-1:0] cnt_final;
  logic                   sat_now;

  assign beat_pulse = beat_in & ~beat_q;
  assign is_run     = (state_q == ST_RUN);
  assign load       = (state_q == ST_IDLE) & start_in & ~stop_in;
  assign clear      = stop_in & (state_q != ST_IDLE);
  assign win_end    = is_run & win_done & ~stop_in;
  assign handshake  = valid_q & ready_in;

  assign at_max    = (beat_cnt_q == CNT_MAX);
  assign cnt_inc   = at_max ? beat_cnt_q : (beat_cnt_q + CNT_ONE);
  assign cnt_final = beat_pulse ? cnt_inc : beat_cnt_q;
  assign sat_now   = sat_q | (beat_pulse & at_max);

  window_timer #(
    .TICK_WIDTH(TICK_WIDTH)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (load),
    .clear_in (clear),
    .window_in(window_ticks_in),
    .tick_in  (tick_in & is_run),
    .done_out (win_done)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    sat_d      = sat_q;
    cont_d     = cont_q;
    result_d   = result_q;
    res_sat_d  = res_sat_q;
    valid_d    = valid_q;
    dropped_d  = dropped_q;

    if (handshake) valid_d = 1'b0;

    // A fresh result outranks a same-cycle acceptance of the old one.
    if (win_end) begin
      valid_d   = 1'b1;
      result_d  = cnt_final;
      res_sat_d = sat_now;
      if (valid_q & ~ready_in) dropped_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_RUN;
          cont_d     = continuous_in;
          beat_cnt_d = '0;
          sat_d      = 1'b0;
          dropped_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop_in) begin
          state_d = ST_IDLE;
        end else if (win_end) begin
          beat_cnt_d = '0;
          sat_d      = 1'b0;
          if (!cont_q) state_d = ST_REPORT;
        end else if (beat_pulse) begin
          beat_cnt_d = cnt_inc;
          sat_d      = sat_now;
        end
      end
      ST_REPORT: begin
        if (stop_in || handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      beat_q     <= 1'b0;
      beat_cnt_q <= '0;
      sat_q      <= 1'b0;
      cont_q     <= 1'b0;
      result_q   <= '0;
      res_sat_q  <= 1'b0;
      valid_q    <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_in;
      beat_cnt_q <= beat_cnt_d;
      sat_q      <= sat_d;
      cont_q     <= cont_d;
      result_q   <= result_d;
      res_sat_q  <= res_sat_d;
      valid_q    <= valid_d;
      dropped_q  <= dropped_d;
    end
  end

  assign result_out  = result_q;
  assign sat_out     = res_sat_q;
  assign valid_out   = valid_q;
  assign busy_out    = (state_q != ST_IDLE);
  assign dropped_out = dropped_q;

endmodule
